// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP, opcodes, fetch-fault bit
// indices, IFU state encoding and the fetch buffer entry layout.
package riscv_pkg;

  localparam int unsigned IFU_INST_W = 32;
  localparam int unsigned IFU_ADDR_W = 64;

  localparam logic [IFU_INST_W-1:0] NOP_INST = 32'h0000_0013; // addi x0,x0,0

  // Major opcodes (inst[6:0]), shared by fetch and decode
  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b001_1011;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_OP32     = 7'b011_1011;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  // fetch_fault bit positions
  localparam int unsigned FAULT_MISALIGN_BIT = 0;
  localparam int unsigned FAULT_ACCESS_BIT   = 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [1:0]            fault;
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush. Flush clears all entries but still
// accepts a push in the same cycle, so the flush cycle can seed one entry.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module ifu_fifo
  import riscv_pkg::*;
#(
  parameter type         T     = fetch_entry_t,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 din_i,
  input  logic             pop_i,
  output T                 dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer / count update; flush wins over pop and restarts at slot 0
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop || flush_i);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    wr_idx  = wr_q;
    if (flush_i) begin
      rd_d   = '0;
      wr_idx = '0;
      wr_d   = do_push ? PTR_W'(1) : '0;
      cnt_d  = do_push ? CNT_W'(1) : '0;
    end else begin
      if (do_pop)  rd_d = nxt(rd_q);
      if (do_push) wr_d = nxt(wr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_idx] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues word reads to imem,
// buffers responses with their PCs and hands them to decode. Redirects
// flush everything and turn in-flight responses into drops.
// Optional build macro IFU_PERF_CNT_EN adds fetched/dropped/bubble counters.
// Note: entry layout uses the package widths, so INST_WIDTH/ADDR_WIDTH must
// match IFU_INST_W/IFU_ADDR_W.
module ifu_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned           INST_WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 64'h8000_0000,
  parameter int unsigned           FIFO_DEPTH      = 2,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [1:0]            fetch_fault_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]           perf_fetched_o,
  output logic [63:0]           perf_dropped_o,
  output logic [63:0]           perf_bubble_o
`endif
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr;
  logic                  hold_q, hold_d, stale_q, stale_d, started_q;
  logic [CNT_W-1:0]      outst_q, outst_d, drop_q, drop_d, live;
  logic                  issue_ok, req_valid, acc, rsp_live;

  logic                  ibuf_push, ibuf_empty, ibuf_full, flush;
  fetch_entry_t          ibuf_din, ibuf_head;
  logic [FCNT_W-1:0]     ibuf_cnt;
  logic                  pend_push, pend_pop, pend_full, pend_empty;
  logic [ADDR_WIDTH-1:0] pend_head;
  logic [CNT_W-1:0]      pend_cnt;
  logic [1:0]            rsp_fault;

  // Request side: a held request always stays on the bus; new ones obey
  // the credit rule and never start in a redirect cycle
  always_comb begin
    live      = outst_q - drop_q;
    issue_ok  = started_q && (state_q == RUN) &&
                (32'(ibuf_cnt) + 32'(live) < 32'(FIFO_DEPTH)) &&
                (32'(outst_q) < 32'(MAX_OUTSTANDING));
    req_valid = hold_q || (issue_ok && !redirect_valid_i);
    req_addr  = hold_q ? req_addr_q : fetch_pc_q;
    acc       = req_valid && imem_req_ready_i;
    hold_d    = req_valid && !imem_req_ready_i;
    rsp_live  = imem_rsp_valid_i && (drop_q == '0);
    rsp_fault = '0;
    rsp_fault[FAULT_ACCESS_BIT] = imem_rsp_err_i;
  end

  // Next-state: redirect overrides everything, otherwise track accepts,
  // responses and drops
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + CNT_W'(acc) - CNT_W'(imem_rsp_valid_i);
    drop_d     = drop_q;
    stale_d    = stale_q && hold_d;
    flush      = 1'b0;
    ibuf_push  = 1'b0;
    ibuf_din   = '0;
    pend_push  = 1'b0;
    pend_pop   = 1'b0;
    if (redirect_valid_i) begin
      // every request still owed a response after this edge is stale
      flush      = 1'b1;
      drop_d     = outst_d;
      stale_d    = hold_d;
      fetch_pc_d = redirect_pc_i;
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d   = FAULT;
        ibuf_push = 1'b1;
        ibuf_din  = '{fault: 2'b01, pc: redirect_pc_i, inst: NOP_INST};
      end else begin
        state_d = RUN;
      end
    end else begin
      if (acc) begin
        if (stale_q) begin
          drop_d = drop_d + 1'b1;
        end else begin
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          pend_push  = 1'b1;
        end
      end
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_d - 1'b1;
      if (rsp_live) begin
        pend_pop  = 1'b1;
        ibuf_push = 1'b1;
        ibuf_din  = '{fault: rsp_fault, pc: pend_head, inst: imem_rsp_data_i};
        if (imem_rsp_err_i) state_d = HALT;
      end
    end
  end

  // Fetch control state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= 1'b0;
      stale_q    <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr;
      hold_q     <= hold_d;
      stale_q    <= stale_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
    end
  end

  ifu_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush),
    .push_i  (ibuf_push),
    .din_i   (ibuf_din),
    .pop_i   (inst_ready_i),
    .dout_o  (ibuf_head),
    .count_o (ibuf_cnt),
    .full_o  (ibuf_full),
    .empty_o (ibuf_empty)
  );

  ifu_fifo #(.T(logic [ADDR_WIDTH-1:0]), .DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush),
    .push_i  (pend_push),
    .din_i   (req_addr),
    .pop_i   (pend_pop),
    .dout_o  (pend_head),
    .count_o (pend_cnt),
    .full_o  (pend_full),
    .empty_o (pend_empty)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = req_addr;
  assign inst_valid_o     = !ibuf_empty;
  assign inst_o           = ibuf_empty ? NOP_INST : ibuf_head.inst;
  assign pc_o             = ibuf_empty ? '0 : ibuf_head.pc;
  assign fetch_fault_o    = ibuf_empty ? 2'b00 : ibuf_head.fault;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetched_q, perf_dropped_q, perf_bubble_q;

  // Event counters, free-running and wrapping
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      if (rsp_live && !redirect_valid_i) perf_fetched_q <= perf_fetched_q + 64'd1;
      if (imem_rsp_valid_i && (redirect_valid_i || drop_q != '0))
        perf_dropped_q <= perf_dropped_q + 64'd1;
      if (inst_ready_i && ibuf_empty) perf_bubble_q <= perf_bubble_q + 64'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_dropped_o = perf_dropped_q;
  assign perf_bubble_o  = perf_bubble_q;
`endif

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (outst_q <= CNT_W'(MAX_OUTSTANDING)) && (drop_q <= outst_q));
  a_pend_track: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (pend_cnt == live) && !(pend_pop && pend_empty) && !(pend_push && pend_full && !pend_pop));
  a_ibuf_room: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (ibuf_push && ibuf_full && !flush) |-> inst_ready_i);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized phase. The
// reference model is the decode-visible stream: after any redirect to T the
// decoder must see T, T+4, ... with data from a fixed address->word map;
// a misaligned target yields one NOP fault entry and then nothing.
module tb_ifu_fetch;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        imem_req_valid_o, imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0, imem_rsp_err_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        inst_valid_o, inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic [1:0]  fetch_fault_o;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetched_o, perf_dropped_o, perf_bubble_o;
`endif

  ifu_fetch dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .pc_o(pc_o), .fetch_fault_o(fetch_fault_o)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched_o), .perf_dropped_o(perf_dropped_o),
    .perf_bubble_o(perf_bubble_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // imem contents and stimulus knobs
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return lo ^ {lo[15:0], lo[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] rnd_target();
    logic [63:0] t;
    t = RST_PC + 64'({$urandom_range(0, 4095), 2'b00});
    if ($urandom_range(0, 4) == 0) t = t + 64'($urandom_range(1, 3));
    return t;
  endfunction

  int          p_req_rdy = 100, p_inst_rdy = 100, p_rsp = 100, p_redir = 0;
  bit          rsp_block = 0, force_redir = 0, err_en = 0;
  logic [63:0] force_pc, err_addr = '0;

  logic [63:0] rspq[$];
  int          rspq_due[$];
  logic [63:0] acc_log[$];
  int          cyc = 0, n_consumed = 0, n_err_seen = 0;
  logic [63:0] exp_pc = RST_PC, first_pc = '0, prev_addr = '0;
  bit          exp_mis = 0, exp_none = 0, first_pend = 1, prev_hold = 0, last_inst_v = 0;

  // One clock cycle: drive inputs at negedge, sample, update model
  task automatic step();
    logic [63:0] a, rpc;
    logic [1:0]  ef;
    bit          redir;
    if (!rsp_block && rspq.size() > 0 && rspq_due[0] <= cyc &&
        int'($urandom_range(0, 99)) < p_rsp) begin
      a = rspq.pop_front();
      void'(rspq_due.pop_front());
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(a);
      imem_rsp_err_i   = err_en && (a == err_addr);
    end
    imem_req_ready_i = int'($urandom_range(0, 99)) < p_req_rdy;
    inst_ready_i     = int'($urandom_range(0, 99)) < p_inst_rdy;
    redir = force_redir || (int'($urandom_range(0, 999)) < p_redir);
    rpc   = force_redir ? force_pc : rnd_target();
    force_redir      = 0;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    #1;
    if (prev_hold) begin
      chk("req_hold_v", {63'd0, imem_req_valid_o}, 64'd1);
      chk("req_hold_addr", imem_req_addr_o, prev_addr);
    end
    if (imem_req_valid_o && imem_req_ready_i) begin
      acc_log.push_back(imem_req_addr_o);
      rspq.push_back(imem_req_addr_o);
      rspq_due.push_back(cyc + 1);
      chk("outst_bound", 64'(rspq.size() <= 2), 64'd1);
    end
    prev_hold   = imem_req_valid_o && !imem_req_ready_i;
    prev_addr   = imem_req_addr_o;
    last_inst_v = inst_valid_o;
    if (inst_valid_o && inst_ready_i) begin
      n_consumed++;
      if (first_pend) begin first_pc = pc_o; first_pend = 0; end
      if (exp_mis) begin
        chk("flt_pc", pc_o, exp_pc);
        chk("flt_inst", 64'(inst_o), 64'(NOP));
        chk("flt_bits", 64'(fetch_fault_o), 64'd1);
        exp_mis = 0; exp_none = 1;
      end else if (exp_none) begin
        chk("stray_inst_v", {63'd0, inst_valid_o}, 64'd0);
      end else begin
        ef = (err_en && exp_pc == err_addr) ? 2'b10 : 2'b00;
        chk("pc", pc_o, exp_pc);
        chk("inst", 64'(inst_o), 64'(mem_word(exp_pc)));
        chk("fault", 64'(fetch_fault_o), 64'(ef));
        if (fetch_fault_o == 2'b10) n_err_seen++;
        exp_pc = exp_pc + 64'd4;
      end
    end
    if (redir) begin
      exp_pc = rpc; exp_mis = (rpc[1:0] != 2'b00); exp_none = 0; first_pend = 1;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    imem_rsp_valid_i = 1'b0; imem_rsp_err_i = 1'b0; redirect_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic redirect_to(input logic [63:0] t);
    force_redir = 1; force_pc = t;
    step();
  endtask

  initial begin
    logic [63:0] held_a;
    // Reset values
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_v", {63'd0, imem_req_valid_o}, 64'd0);
    chk("rst_inst_v", {63'd0, inst_valid_o}, 64'd0);
    chk("rst_fault", 64'(fetch_fault_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'(NOP));
    rst_n_i = 1'b1;

    // Decode stalled: exactly two fetches, no bypass, then resume at +8
    p_inst_rdy = 0;
    step(); step(); step();
    chk("no_bypass", {63'd0, last_inst_v}, 64'd0);
    step();
    chk("rsp_visible", {63'd0, last_inst_v}, 64'd1);
    repeat (4) step();
    chk("stall_acc_n", 64'(acc_log.size()), 64'd2);
    chk("stall_acc0", acc_log.size() > 0 ? acc_log[0] : '1, RST_PC);
    chk("stall_acc1", acc_log.size() > 1 ? acc_log[1] : '1, RST_PC + 64'd4);
    chk("stall_req_v", {63'd0, imem_req_valid_o}, 64'd0);
    acc_log.delete();
    p_inst_rdy = 100;
    repeat (10) step();
    chk("resume_addr", acc_log.size() > 0 ? acc_log[0] : '1, RST_PC + 64'd8);
    chk("stream_n", 64'(n_consumed > 6), 64'd1);

    // Redirect with two responses owed
    rsp_block = 1;
    repeat (6) step();
    chk("t3_outst", 64'(rspq.size()), 64'd2);
    redirect_to(64'h8000_1000);
    rsp_block = 0;
    repeat (10) step();
    chk("t3_first_pc", first_pc, 64'h8000_1000);

    // Redirect while a request is stuck on the bus
    p_req_rdy = 0;
    repeat (3) step();
    chk("t4_v", {63'd0, imem_req_valid_o}, 64'd1);
    held_a = imem_req_addr_o;
    redirect_to(64'h8000_2000);
    repeat (3) begin
      step();
      chk("t4_addr", imem_req_addr_o, held_a);
    end
    acc_log.delete();
    p_req_rdy = 100;
    repeat (8) step();
    chk("t4_acc0", acc_log.size() > 0 ? acc_log[0] : '1, held_a);
    chk("t4_acc1", acc_log.size() > 1 ? acc_log[1] : '1, 64'h8000_2000);
    chk("t4_first_pc", first_pc, 64'h8000_2000);

    // Misaligned redirect
    p_inst_rdy = 0;
    redirect_to(64'h8000_0102);
    acc_log.delete();
    repeat (6) step();
    chk("t5_inst_v", {63'd0, inst_valid_o}, 64'd1);
    chk("t5_inst", 64'(inst_o), 64'(NOP));
    chk("t5_fault", 64'(fetch_fault_o), 64'd1);
    chk("t5_pc", pc_o, 64'h8000_0102);
    chk("t5_req_v", {63'd0, imem_req_valid_o}, 64'd0);
    chk("t5_acc_n", 64'(acc_log.size()), 64'd0);
    p_inst_rdy = 100;
    repeat (3) step();
    redirect_to(64'h8000_3000);
    repeat (10) step();
    chk("t5_restart_pc", first_pc, 64'h8000_3000);

    // Access fault halts fetch
    err_en = 1; err_addr = 64'h8000_4008;
    acc_log.delete();
    redirect_to(64'h8000_4000);
    repeat (15) step();
    chk("t6_err_seen", 64'(n_err_seen), 64'd1);
    chk("t6_req_v", {63'd0, imem_req_valid_o}, 64'd0);
    chk("t6_acc_bound", 64'(acc_log.size() <= 4), 64'd1);
    err_en = 0;

    // Randomized traffic with occasional redirects
    p_req_rdy = 70; p_inst_rdy = 60; p_rsp = 60; p_redir = 20;
    n_consumed = 0;
    redirect_to(64'h8000_5000);
    repeat (3000) step();
    chk("rnd_progress", 64'(n_consumed > 100), 64'd1);

    // Async reset while the buffer holds data
    p_req_rdy = 100; p_inst_rdy = 0; p_rsp = 100; p_redir = 0;
    redirect_to(64'h8000_6000);
    repeat (10) step();
    chk("pre_rst_v", {63'd0, inst_valid_o}, 64'd1);
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    chk("arst_req_v", {63'd0, imem_req_valid_o}, 64'd0);
    chk("arst_inst_v", {63'd0, inst_valid_o}, 64'd0);
    chk("arst_fault", 64'(fetch_fault_o), 64'd0);
    chk("arst_inst", 64'(inst_o), 64'(NOP));
    rspq.delete(); rspq_due.delete(); acc_log.delete();
    prev_hold = 0; exp_pc = RST_PC; exp_mis = 0; exp_none = 0; first_pend = 1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    p_inst_rdy = 100;
    repeat (8) step();
    chk("arst_acc0", acc_log.size() > 0 ? acc_log[0] : '1, RST_PC);
    chk("arst_first_pc", first_pc, RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
